// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB bus widths and completer state encoding
package apb_pkg;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - DEPTH x DATA_W register file, sync write, async clear, comb read
module apb_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W,
  parameter int DEPTH  = 32
) (
  input  logic              pclk,
  input  logic              Reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (IDX_W > ADDR_W) begin : g_depth_chk
    $error("apb_regfile: DEPTH does not fit in ADDR_W address bits");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              waddr_ok;
  logic              raddr_ok;

  assign waddr_ok = int'(waddr_i) < DEPTH;
  assign raddr_ok = int'(raddr_i) < DEPTH;

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && waddr_ok) begin
      mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  // Out-of-range reads return zero rather than aliasing onto a real word.
  assign rdata_o = raddr_ok ? mem_q[raddr_i[IDX_W-1:0]] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with register file and programmable wait states
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              pclk,
  input  logic              Reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_chk
    $error("apb_slave_mem: WAIT_CYCLES must be within 0..15");
  end

  localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

  apb_state_e        state_q;
  logic [3:0]        cnt_q;
  logic              acc_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wd_q;
  logic              pready_q;
  logic              pslverr_q;
  logic [DATA_W-1:0] prdata_q;

  logic              load_d;
  logic              addr_ok_d;
  logic              commit_d;
  logic [DATA_W-1:0] rd_data_d;

  assign load_d    = psel && !penable && (state_q != WAIT);
  assign addr_ok_d = int'(addr_q) < DEPTH;
  assign commit_d  = (state_q == READY) && wr_q && psel && !pslverr_q;

  apb_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .pclk    (pclk),
    .Reset   (Reset),
    .we_i    (commit_d),
    .waddr_i (addr_q),
    .wdata_i (wd_q),
    .raddr_i (addr_q),
    .rdata_o (rd_data_d)
  );

  // acc_q marks that the access phase has been entered; the first penable
  // edge only registers that entry, so pready lands at T1+1+WAIT_CYCLES.
  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wd_q      <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      if (load_d) begin
        addr_q <= paddr;
        wr_q   <= pwrite;
        wd_q   <= pwdata;
        cnt_q  <= WAIT_INIT;
        acc_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (load_d) state_q <= WAIT;
        end
        WAIT: begin
          if (!psel) begin
            state_q <= IDLE;
          end else if (penable) begin
            if (!acc_q) begin
              acc_q <= 1'b1;
            end else if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              state_q   <= READY;
              pready_q  <= 1'b1;
              pslverr_q <= !addr_ok_d;
              if (!wr_q) prdata_q <= rd_data_d;
            end
          end
        end
        READY: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= load_d ? WAIT : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - randomized self-checking bench for apb_slave_mem
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        Reset;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [4:0]  paddr   [3];
  logic [31:0] pwdata  [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int          wc [3] = '{1, 0, 4};
  int          dp [3] = '{32, 16, 20};
  logic [31:0] mem_m [3][32];

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem #(.DEPTH(32), .WAIT_CYCLES(1)) u_dut0 (
    .pclk(pclk), .Reset(Reset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );
  apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut1 (
    .pclk(pclk), .Reset(Reset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );
  apb_slave_mem #(.DEPTH(20), .WAIT_CYCLES(4)) u_dut2 (
    .pclk(pclk), .Reset(Reset), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
    .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2])
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 32; i++)
        mem_m[d][i] = 32'h0;
  endtask

  // Called at a negedge; returns at the negedge where pready is seen, psel/penable still high.
  task automatic xfer(input int d, input logic wr, input logic [4:0] a,
                      input logic [31:0] wd, input logic scramble);
    int   n;
    logic exp_err;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge pclk);
    @(negedge pclk);
    chk_eq("pready_in_setup", {31'b0, pready[d]}, 32'h0);
    penable[d] = 1'b1;
    if (scramble) begin
      paddr[d]  = 5'($urandom);
      pwdata[d] = $urandom;
    end
    n = 0;
    while (n < 40) begin
      @(posedge pclk);
      n++;
      @(negedge pclk);
      if (pready[d]) break;
    end
    exp_err = int'(a) >= dp[d];
    chk_eq($sformatf("latency d%0d", d), n, 2 + wc[d]);
    chk_eq($sformatf("pslverr d%0d a%0d", d, a), {31'b0, pslverr[d]}, {31'b0, exp_err});
    if (!wr)
      chk_eq($sformatf("prdata d%0d a%0d", d, a), prdata[d], exp_err ? 32'h0 : mem_m[d][a]);
    else if (!exp_err)
      mem_m[d][a] = wd;
  endtask

  task automatic end_xfer(input int d);
    @(posedge pclk);
    @(negedge pclk);
    chk_eq("pready_one_cycle", {31'b0, pready[d]}, 32'h0);
    chk_eq("pslverr_cleared", {31'b0, pslverr[d]}, 32'h0);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic rd(input int d, input logic [4:0] a);
    xfer(d, 1'b0, a, 32'h0, 1'b0);
    end_xfer(d);
  endtask

  initial begin
    Reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
    end
    clear_model();
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    for (int d = 0; d < 3; d++) begin
      chk_eq("rst_pready", {31'b0, pready[d]}, 32'h0);
      chk_eq("rst_pslverr", {31'b0, pslverr[d]}, 32'h0);
      chk_eq("rst_prdata", prdata[d], 32'h0);
    end
    Reset = 1'b0;
    @(negedge pclk);

    xfer(0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0); end_xfer(0);
    rd(0, 5'd7);
    rd(0, 5'd3);

    xfer(0, 1'b1, 5'd0, 32'h00000011, 1'b0);
    xfer(0, 1'b0, 5'd0, 32'h0, 1'b0);
    end_xfer(0);

    xfer(1, 1'b1, 5'd2, 32'hCAFE0002, 1'b1); end_xfer(1);
    xfer(1, 1'b0, 5'd2, 32'h0, 1'b1); end_xfer(1);
    xfer(2, 1'b1, 5'd9, 32'h0BAD0009, 1'b1); end_xfer(2);
    xfer(2, 1'b0, 5'd9, 32'h0, 1'b1); end_xfer(2);

    xfer(1, 1'b1, 5'd4, 32'h12345678, 1'b0); end_xfer(1);
    xfer(1, 1'b1, 5'd20, 32'hA5A5A5A5, 1'b0); end_xfer(1);
    rd(1, 5'd20);
    rd(1, 5'd4);

    // psel+penable without a setup phase must be ignored
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 5'd1; pwrite[0] = 1'b1;
    repeat (4) begin
      @(posedge pclk); @(negedge pclk);
      chk_eq("idle_penable_ignored", {31'b0, pready[0]}, 32'h0);
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge pclk);

    xfer(0, 1'b1, 5'd5, 32'h55555555, 1'b0); end_xfer(0);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 5'd5; pwdata[0] = 32'h99999999;
    @(posedge pclk); @(negedge pclk);
    penable[0] = 1'b1;
    @(posedge pclk); @(negedge pclk);
    psel[0] = 1'b0; penable[0] = 1'b0;
    repeat (4) begin
      @(posedge pclk); @(negedge pclk);
      chk_eq("abort_no_pready", {31'b0, pready[0]}, 32'h0);
    end
    rd(0, 5'd5);

    for (int c = 0; c < 25; c++) begin
      int d;
      int k;
      d = $urandom_range(0, 2);
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++)
        xfer(d, 1'($urandom), 5'($urandom), $urandom, 1'($urandom));
      end_xfer(d);
    end

    xfer(2, 1'b1, 5'd2, 32'h22222222, 1'b0); end_xfer(2);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 5'd2; pwdata[2] = 32'h77777777;
    @(posedge pclk); @(negedge pclk);
    penable[2] = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    #2 Reset = 1'b1;
    #1;
    chk_eq("midwait_rst_pready", {31'b0, pready[2]}, 32'h0);
    chk_eq("midwait_rst_prdata", prdata[2], 32'h0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    clear_model();
    @(negedge pclk);
    Reset = 1'b0;
    @(negedge pclk);
    rd(2, 5'd2);
    rd(0, 5'd3);
    rd(1, 5'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
